cnt_gen: RTL
============

Name: cnt_gen

Overview:
Programmable count-sequence generator that produces the `CNT_W-bit count bus consumed by the downstream count-sequence detector.
- Supports wrap-up, wrap-down, bounce (up/down) and one-shot modes with a run-time limit, synchronous load and start/stop control.
- Produces a terminal-count pulse and status flags.
- Count width is `CNT_W from src/defines.v.

Parameters:
- RST_VAL, 0: value of cnt after reset.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- start  input  1  pulse; begin counting from IDLE/DONE
- stop  input  1  pulse; abort to IDLE, cnt holds
- load  input  1  synchronous load of load_val
- load_val  input  `CNT_W  value to load
- limit  input  `CNT_W  upper bound of count range, 0..limit inclusive
- mode  input  2  00 wrap-up, 01 wrap-down, 10 bounce, 11 one-shot up; sampled only on accepted start
- cnt  output  `CNT_W  registered count
- running  output  1  high in RUN_UP/RUN_DN
- tc  output  1  one-cycle pulse when cnt steps onto its terminal value
- done  output  1  high in DONE (one-shot finished)

Behaviour:
- Reset (rstn low, async):
  - state=IDLE, cnt=RST_VAL, mode_q=00.
  - running=0, tc=0, done=0.
- States:
  - IDLE: cnt holds. start -> RUN_DN if mode=01, else RUN_UP; mode latched into mode_q.
  - RUN_UP: cnt+1 each step.
    - At cnt==limit, by mode_q:
      - 00: next cnt=0, stay.
      - 10: next cnt=limit-1, go RUN_DN.
      - 11: hold, go DONE.
    - If cnt>limit (limit lowered while running): next cnt=0.
  - RUN_DN: cnt-1 each step.
    - At cnt==0, by mode_q:
      - 01: next cnt=limit, stay.
      - 10: next cnt=1, go RUN_UP.
  - DONE: cnt holds limit, done=1. start restarts as from IDLE, cnt first reset to 0 for up modes.
- Start value:
  - Starting an up-mode from IDLE/DONE continues from the current cnt, except DONE, which restarts at 0.
  - Starting wrap-down continues from the current cnt.
- Priority, same cycle: load > stop > start > counting step.
  - load: cnt<=min(load_val, limit); state unchanged; no tc; no step that cycle.
  - stop in any state: -> IDLE next cycle, cnt holds, tc=0.
  - start while already running: ignored.
- Registered outputs:
  - tc is registered: high for exactly the one cycle in which cnt first shows limit (up) or 0 (down) as the result of a counting step. Never set by load or reset.
  - running and done are registered decodes of the next state, so they are valid the same cycle the state is.
- limit=0:
  - cnt stays 0.
  - Wrap/bounce modes: tc high every step cycle.
  - One-shot: first step goes DONE with tc=1.
- Bounce with limit=1: sequence 0,1,0,1,...; tc on every step.
- Arithmetic is modulo 2^`CNT_W internally, but the limit checks above prevent overflow wrap.
- Latency: first changed cnt appears the cycle after start is accepted.

Optional Feature:
- Macro: CNT_GEN_PRESCALE_EN.
- Defined:
  - Adds parameter PRE_DIV (default 4, >=1) and an internal prescale counter.
  - Counting steps occur only on cycles where the prescale counter equals PRE_DIV-1, so cnt holds each value for PRE_DIV cycles.
  - The prescaler clears on reset, start, stop and load.
  - tc is asserted only on step cycles.
- Not defined: a step occurs every clock cycle in RUN states; no prescaler logic exists.

Test Plan:
1. Reset mid-run: assert rstn=0 at cnt=3 -> cnt=RST_VAL(0), running=0, tc=0 asynchronously.
2. mode=00, limit=6, start from cnt=0 -> cnt 1,2,3,4,5,6,0,1,... on consecutive cycles; tc=1 only in cycles with cnt=6; values 4,5,6 appear back-to-back.
3. mode=10, limit=3 -> cnt 1,2,3,2,1,0,1; tc with cnt=3 and cnt=0.
4. mode=11, limit=2 -> cnt 1,2 then DONE: done=1, running=0, cnt held 2; a second start -> cnt 0 then 1.
5. load=1, stop=1, start=1 in the same cycle with load_val=9, limit=6 -> cnt=6, state IDLE, tc=0.
6. With CNT_GEN_PRESCALE_EN, PRE_DIV=3, mode=00, limit=2 -> each cnt value held 3 cycles; tc high 1 cycle per wrap.

Source files
------------

// File: rtl/cnt_gen.sv
// cnt_gen: programmable count-sequence generator (wrap-up, wrap-down, bounce, one-shot).
// Define CNT_GEN_PRESCALE_EN to add the PRE_DIV step prescaler; CNT_W defaults to 8 if not predefined.
`ifndef CNT_W
`define CNT_W 8
`endif

module cnt_gen #(
  parameter logic [`CNT_W-1:0] RST_VAL = {`CNT_W{1'b0}}
`ifdef CNT_GEN_PRESCALE_EN
  ,
  parameter int unsigned PRE_DIV = 4
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic [`CNT_W-1:0] load_val,
  input  logic [`CNT_W-1:0] limit,
  input  logic [1:0]        mode,
  output logic [`CNT_W-1:0] cnt,
  output logic              running,
  output logic              tc,
  output logic              done
);

  localparam int W = `CNT_W;
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DN   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] M_WRAP_UP = 2'b00;
  localparam logic [1:0] M_WRAP_DN = 2'b01;
  localparam logic [1:0] M_BOUNCE  = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  logic [1:0]   r_state;
  logic [1:0]   r_mode_q;
  logic [W-1:0] r_cnt;
  logic         r_tc;
  logic         r_running;
  logic         r_done;

  logic [1:0]   w_state_nxt;
  logic [1:0]   w_mode_nxt;
  logic [W-1:0] w_cnt_nxt;
  logic         w_tc_nxt;

  logic         w_is_run;
  logic         w_start_acc;
  logic         w_step_en;
  logic [1:0]   w_run_st;
  logic [1:0]   w_run_md;
  logic [W-1:0] w_s_cnt;
  logic [1:0]   w_s_state;
  logic         w_s_tc;

  assign w_is_run    = (r_state == S_UP) || (r_state == S_DN);
  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef CNT_GEN_PRESCALE_EN
  localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          w_pre_clr;

  assign w_pre_clr = load || stop || w_start_acc;
  assign w_step_en = (r_pre == PRE_LAST);

  // Prescaler only advances in RUN states; it sits at zero elsewhere so a start lines up cleanly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre <= {PW{1'b0}};
    end else if (w_pre_clr || !w_is_run || w_step_en) begin
      r_pre <= {PW{1'b0}};
    end else begin
      r_pre <= r_pre + {{(PW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign w_step_en = 1'b1;
`endif

  // One counting step taken from the current cnt, in the state/mode that applies this cycle.
  always_comb begin
    w_run_st  = r_state;
    w_run_md  = r_mode_q;
    if (w_start_acc) begin
      w_run_md = mode;
      w_run_st = (mode == M_WRAP_DN) ? S_DN : S_UP;
    end else begin
      w_run_md = r_mode_q;
    end
    w_s_cnt   = r_cnt;
    w_s_state = w_run_st;
    w_s_tc    = 1'b0;
    if (w_run_st == S_UP) begin
      if (r_cnt > limit) begin
        w_s_cnt = ZERO;
        w_s_tc  = (limit == ZERO);
      end else if (r_cnt == limit) begin
        case (w_run_md)
          M_BOUNCE: begin
            w_s_state = S_DN;
            w_s_cnt   = (limit == ZERO) ? ZERO : (limit - ONE);
            w_s_tc    = (limit <= ONE);
          end
          M_ONESHOT: begin
            w_s_state = S_DONE;
            w_s_cnt   = r_cnt;
            w_s_tc    = (limit == ZERO);
          end
          default: begin
            w_s_cnt = ZERO;
            w_s_tc  = (limit == ZERO);
          end
        endcase
      end else begin
        w_s_cnt = r_cnt + ONE;
        w_s_tc  = ((r_cnt + ONE) == limit);
      end
    end else if (w_run_st == S_DN) begin
      if (r_cnt != ZERO) begin
        w_s_cnt = r_cnt - ONE;
        w_s_tc  = (r_cnt == ONE);
      end else begin
        case (w_run_md)
          M_BOUNCE: begin
            // Bounce turns around at zero; limit=0 pins cnt at 0.
            w_s_state = S_UP;
            w_s_cnt   = (limit == ZERO) ? ZERO : ONE;
            w_s_tc    = (limit <= ONE);
          end
          default: begin
            w_s_cnt = limit;
            w_s_tc  = (limit == ZERO);
          end
        endcase
      end
    end else begin
      w_s_cnt = r_cnt;
    end
  end

  // Next-state selection with load > stop > start > step priority.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode_q;
    w_tc_nxt    = 1'b0;
    if (load) begin
      w_cnt_nxt = (load_val > limit) ? limit : load_val;
    end else if (stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start_acc) begin
      w_mode_nxt = mode;
      if ((r_state == S_DONE) && (mode != M_WRAP_DN)) begin
        w_state_nxt = S_UP;
        w_cnt_nxt   = ZERO;
      end else if (w_step_en) begin
        w_state_nxt = w_s_state;
        w_cnt_nxt   = w_s_cnt;
        w_tc_nxt    = w_s_tc;
      end else begin
        w_state_nxt = w_run_st;
      end
    end else if (w_is_run && w_step_en) begin
      w_state_nxt = w_s_state;
      w_cnt_nxt   = w_s_cnt;
      w_tc_nxt    = w_s_tc;
    end else begin
      w_tc_nxt = 1'b0;
    end
  end

  // State, count and registered status decodes of the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= RST_VAL;
      r_mode_q  <= M_WRAP_UP;
      r_tc      <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mode_q  <= w_mode_nxt;
      r_tc      <= w_tc_nxt;
      r_running <= (w_state_nxt == S_UP) || (w_state_nxt == S_DN);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  assign cnt     = r_cnt;
  assign running = r_running;
  assign tc      = r_tc;
  assign done    = r_done;

endmodule
